// File: rtl/accum_arbiter_pkg.sv
// Shared constants and helpers for the round-robin accumulating arbiter.
package accum_arbiter_pkg;

  localparam int DEFAULT_NUM_REQ = 4;
  localparam int DEFAULT_WIDTH   = 32;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: lowest-numbered valid request at or after ptr, wrapping.
module rr_arbiter
  import accum_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]            req,
  input  logic [idx_width(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]            grant
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [2*NUM_REQ-1:0] gnt_dbl;
  logic [NUM_REQ-1:0]   rot_req;
  logic [NUM_REQ-1:0]   rot_gnt;

  // Rotate so ptr sits at bit 0, pick the lowest set bit, rotate back.
  always_comb begin
    req_dbl = {req, req} >> ptr;
    rot_req = req_dbl[NUM_REQ-1:0];
    rot_gnt = rot_req & (-rot_req);
    gnt_dbl = {{NUM_REQ{1'b0}}, rot_gnt} << ptr;
    grant   = gnt_dbl[NUM_REQ-1:0] | gnt_dbl[2*NUM_REQ-1:NUM_REQ];
  end

endmodule

// File: rtl/accum_arbiter.sv
// Per-requester accumulators sharing one adder behind a round-robin arbiter.
// Define ACCUM_ARBITER_OVERFLOW_EN to report the adder carry-out on rsp_ovf.
module accum_arbiter
  import accum_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int WIDTH   = DEFAULT_WIDTH
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]       req_data,
  input  logic [NUM_REQ-1:0]             req_clear,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [idx_width(NUM_REQ)-1:0]  rsp_id,
  output logic [WIDTH-1:0]               rsp_data,
  output logic                           rsp_ovf,
  output logic [NUM_REQ*WIDTH-1:0]       acc_value
);

  localparam int            IW      = idx_width(NUM_REQ);
  localparam logic [IW-1:0] LAST_ID = IW'(NUM_REQ - 1);

  logic [WIDTH-1:0]   acc [NUM_REQ];
  logic [IW-1:0]      ptr;
  logic [NUM_REQ-1:0] grant;
  logic               stall;
  logic               xfer;
  logic [IW-1:0]      win_id;
  logic [WIDTH-1:0]   sel_data;
  logic [WIDTH-1:0]   sel_acc;
  logic               sel_clear;
  logic [WIDTH-1:0]   new_val;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  // An unaccepted response blocks every requester so the output can hold.
  assign stall     = rsp_valid && !rsp_ready;
  assign req_ready = (reset_n && !stall) ? grant : '0;
  assign xfer      = |req_ready;

  always_comb begin
    win_id    = '0;
    sel_data  = '0;
    sel_acc   = '0;
    sel_clear = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win_id    = IW'(i);
        sel_data  = req_data[i*WIDTH +: WIDTH];
        sel_acc   = acc[i];
        sel_clear = req_clear[i];
      end
    end
  end

`ifdef ACCUM_ARBITER_OVERFLOW_EN
  logic [WIDTH:0] sum;
  logic           new_carry;

  assign sum       = {1'b0, sel_acc} + {1'b0, sel_data};
  assign new_val   = sel_clear ? sel_data : sum[WIDTH-1:0];
  assign new_carry = !sel_clear && sum[WIDTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp_ovf <= 1'b0;
    end else if (xfer) begin
      rsp_ovf <= new_carry;
    end
  end
`else
  assign new_val = sel_clear ? sel_data : sel_acc + sel_data;
  assign rsp_ovf = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        acc[i] <= '0;
      end
    end else if (xfer) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) begin
          acc[i] <= new_val;
        end
      end
      ptr       <= (win_id == LAST_ID) ? '0 : win_id + IW'(1);
      rsp_valid <= 1'b1;
      rsp_id    <= win_id;
      rsp_data  <= new_val;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_acc
    assign acc_value[g*WIDTH +: WIDTH] = acc[g];
  end

endmodule
